mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/riscy_mem_pkg.sv | 29 ++
 rtl/rr_arbiter2.sv | 32 +++
 rtl/mem_port_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscy_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscy_mem_pkg
//  Description : Shared definitions for the memory-port arbiter: default bus
//                widths, requester identifiers and the arbiter FSM state type.
//  Contents    : DEFAULT_ADDR_W / DEFAULT_DATA_W - default bus widths
//                REQ_I / REQ_D                   - requester IDs (fetch/data)
//                arb_state_e                     - arbiter FSM states
//  Revision    : 1.0 - initial release
// ============================================================================
package riscy_mem_pkg;

  localparam int DEFAULT_ADDR_W = 32;
  localparam int DEFAULT_DATA_W = 32;

  // Requester identifiers; also the bit index of each requester in the
  // valid/grant vectors of the round-robin arbiter.
  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_e;

endpackage : riscy_mem_pkg
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Two-way round-robin grant logic (purely combinational).
//                A lone valid requester is granted; when both are valid the
//                requester that was not granted last wins.
//  Ports       : valid[1:0] in  - request valids, index = requester ID
//                last       in  - ID of the most recently granted requester
//                grant[1:0] out - one-hot grant (all zero when no valid)
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
  import riscy_mem_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // Contention: hand the port to whoever did not have it last time.
      2'b11:   grant = (last == REQ_D) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-ported synchronous memory between an
//                instruction-fetch port (read only) and a load/store port.
//                One transaction is in flight at a time:
//                IDLE (accept) -> ACCESS (mem_en) -> WAIT (capture) -> RESP.
//  Ports       : CLK, resetn                 - clock, sync active-low reset
//                i_req_valid/ready, i_addr   - fetch request
//                i_rsp_valid, i_rdata        - fetch response
//                d_req_valid/ready, d_addr,
//                d_wmask, d_wdata            - load/store request
//                d_rsp_valid, d_rdata        - load/store response
//                mem_en, mem_addr, mem_wmask,
//                mem_wdata, mem_rdata        - memory port (1-cycle read)
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import riscy_mem_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic                CLK,
  input  logic                resetn,

  input  logic                i_req_valid,
  output logic                i_req_ready,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_rsp_valid,
  output logic [DATA_W-1:0]   i_rdata,

  input  logic                d_req_valid,
  output logic                d_req_ready,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W/8-1:0] d_wmask,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_rsp_valid,
  output logic [DATA_W-1:0]   d_rdata,

  output logic                mem_en,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_wmask,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int MASK_W = DATA_W / 8;

  // Clears the byte-offset bits so every memory access is word aligned.
  localparam logic [ADDR_W-1:0] WORD_ALIGN = ~ADDR_W'(3);

  arb_state_e        state;
  arb_state_e        state_next;

  logic [1:0]        grant;
  logic              accept;
  logic              grant_id;
  logic              last_grant;

  // Latched transaction
  logic              req_id;
  logic [ADDR_W-1:0] addr_q;
  logic [MASK_W-1:0] wmask_q;
  logic [DATA_W-1:0] wdata_q;

  // Per-requester response data; each holds until its next response.
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  rr_arbiter2 u_rr_arbiter2 (
    .valid ({d_req_valid, i_req_valid}),
    .last  (last_grant),
    .grant (grant)
  );

  assign grant_id = grant[REQ_D] ? REQ_D : REQ_I;

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    i_req_ready = 1'b0;
    d_req_ready = 1'b0;
    mem_en      = 1'b0;
    mem_wmask   = '0;
    i_rsp_valid = 1'b0;
    d_rsp_valid = 1'b0;

    case (state)
      ST_IDLE: begin
        // Ready follows the request valids in the same cycle. It is also
        // gated by resetn so nothing is handshaken while reset is applied.
        if (resetn && (grant != 2'b00)) begin
          accept      = 1'b1;
          i_req_ready = grant[REQ_I];
          d_req_ready = grant[REQ_D];
          state_next  = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        mem_en     = 1'b1;
        mem_wmask  = wmask_q;
        state_next = ST_WAIT;
      end

      ST_WAIT: begin
        state_next = ST_RESP;
      end

      ST_RESP: begin
        i_rsp_valid = (req_id == REQ_I);
        d_rsp_valid = (req_id == REQ_D);
        state_next  = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      last_grant <= REQ_D;   // so fetch wins the first contended grant
      req_id     <= REQ_I;
      addr_q     <= '0;
      wmask_q    <= '0;      // a pending write is dropped on reset
      wdata_q    <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state <= state_next;

      if (accept) begin
        req_id     <= grant_id;
        last_grant <= grant_id;
        if (grant_id == REQ_D) begin
          addr_q  <= d_addr & WORD_ALIGN;
          wmask_q <= d_wmask;
          wdata_q <= d_wdata;
        end else begin
          // Fetches are reads: never let a stale mask through.
          addr_q  <= i_addr & WORD_ALIGN;
          wmask_q <= '0;
          wdata_q <= '0;
        end
      end

      // Memory read data is valid in the cycle after mem_en, i.e. in WAIT.
      if (state == ST_WAIT) begin
        if (req_id == REQ_I) begin
          i_rdata_q <= (wmask_q != '0) ? '0 : mem_rdata;
        end else begin
          d_rdata_q <= (wmask_q != '0) ? '0 : mem_rdata;
        end
      end
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter. A word-array
//                memory model answers the memory port; a transaction-level
//                reference (grant decision, fixed response timeline and a
//                golden memory image) predicts every port each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MASK_W = DATA_W / 8;
  localparam int WORDS  = 64;

  logic              CLK = 1'b0;
  logic              resetn = 1'b0;
  logic              i_req_valid = 1'b0;
  logic              i_req_ready;
  logic [ADDR_W-1:0] i_addr = '0;
  logic              i_rsp_valid;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req_valid = 1'b0;
  logic              d_req_ready;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [MASK_W-1:0] d_wmask = '0;
  logic [DATA_W-1:0] d_wdata = '0;
  logic              d_rsp_valid;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [MASK_W-1:0] mem_wmask;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLK         (CLK),
    .resetn      (resetn),
    .i_req_valid (i_req_valid),
    .i_req_ready (i_req_ready),
    .i_addr      (i_addr),
    .i_rsp_valid (i_rsp_valid),
    .i_rdata     (i_rdata),
    .d_req_valid (d_req_valid),
    .d_req_ready (d_req_ready),
    .d_addr      (d_addr),
    .d_wmask     (d_wmask),
    .d_wdata     (d_wdata),
    .d_rsp_valid (d_rsp_valid),
    .d_rdata     (d_rdata),
    .mem_en      (mem_en),
    .mem_addr    (mem_addr),
    .mem_wmask   (mem_wmask),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  always #5 CLK = ~CLK;

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Memory behind the port: registered read, byte-masked write
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] slave_mem [WORDS];
  logic [DATA_W-1:0] ref_mem   [WORDS];

  always @(posedge CLK) begin
    if (mem_en) begin
      mem_rdata <= slave_mem[mem_addr[7:2]];
      for (int b = 0; b < MASK_W; b++)
        if (mem_wmask[b]) slave_mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  // --------------------------------------------------------------------------
  // Reference model, evaluated once per cycle at the falling edge.
  // A request accepted in cycle N owns the port for N..N+3: memory strobe
  // in N+1, response pulse (and new rdata) in N+3, port free again in N+4.
  // --------------------------------------------------------------------------
  int unsigned       cyc = 0;
  bit                t_active = 1'b0;
  int unsigned       t_cyc = 0;
  int                t_id = 0;
  logic [ADDR_W-1:0] t_addr = '0;
  logic [MASK_W-1:0] t_mask = '0;
  logic [DATA_W-1:0] t_wdata = '0;
  logic [DATA_W-1:0] t_rexp = '0;
  int                m_last = 1;       // 0 = fetch, 1 = data
  logic [DATA_W-1:0] m_i_rdata = '0;
  logic [DATA_W-1:0] m_d_rdata = '0;

  bit                i_acc_seen = 1'b0;
  bit                d_acc_seen = 1'b0;
  int                men_cnt = 0;
  int                irsp_cnt = 0;
  logic [ADDR_W-1:0] last_men_addr = '0;
  logic [MASK_W-1:0] last_men_wmask = '0;
  bit                log_en = 1'b0;
  int                grant_id_q[$];
  int unsigned       grant_cyc_q[$];

  initial begin
    forever begin
      bit e_men, e_irsp, e_drsp;
      int g;
      int idx;
      @(negedge CLK);

      if (t_active && (cyc >= t_cyc + 4)) t_active = 1'b0;
      e_men  = t_active && (cyc == t_cyc + 1);
      e_irsp = t_active && (cyc == t_cyc + 3) && (t_id == 0);
      e_drsp = t_active && (cyc == t_cyc + 3) && (t_id == 1);
      if (e_irsp) m_i_rdata = t_rexp;
      if (e_drsp) m_d_rdata = t_rexp;

      g = -1;
      if (resetn && !t_active) begin
        if (i_req_valid && d_req_valid) g = (m_last == 1) ? 0 : 1;
        else if (i_req_valid)           g = 0;
        else if (d_req_valid)           g = 1;
      end

      check_eq("i_req_ready", i_req_ready, g == 0);
      check_eq("d_req_ready", d_req_ready, g == 1);
      check_eq("mem_en", mem_en, e_men);
      if (e_men) begin
        check_eq("mem_addr", mem_addr, t_addr & ~32'h3);
        check_eq("mem_wmask", mem_wmask, t_mask);
        if (t_mask != '0) check_eq("mem_wdata", mem_wdata, t_wdata);
      end else begin
        check_eq("mem_wmask_idle", mem_wmask, 0);
      end
      check_eq("i_rsp_valid", i_rsp_valid, e_irsp);
      check_eq("d_rsp_valid", d_rsp_valid, e_drsp);
      check_eq("i_rdata", i_rdata, m_i_rdata);
      check_eq("d_rdata", d_rdata, m_d_rdata);

      i_acc_seen = i_req_valid && i_req_ready;
      d_acc_seen = d_req_valid && d_req_ready;
      if (mem_en) begin
        men_cnt++;
        last_men_addr  = mem_addr;
        last_men_wmask = mem_wmask;
      end
      if (i_rsp_valid) irsp_cnt++;
      if (log_en && (i_acc_seen || d_acc_seen)) begin
        grant_id_q.push_back(d_acc_seen ? 1 : 0);
        grant_cyc_q.push_back(cyc);
      end

      if (g >= 0) begin
        t_active = 1'b1;
        t_cyc    = cyc;
        t_id     = g;
        t_addr   = (g == 0) ? i_addr : d_addr;
        t_mask   = (g == 0) ? '0 : d_wmask;
        t_wdata  = d_wdata;
        idx      = int'(t_addr[7:2]);
        t_rexp   = (t_mask != '0) ? '0 : ref_mem[idx];
        for (int b = 0; b < MASK_W; b++)
          if (t_mask[b]) ref_mem[idx][8*b +: 8] = t_wdata[8*b +: 8];
        m_last = g;
      end

      if (!resetn) begin
        t_active  = 1'b0;
        m_last    = 1;
        m_i_rdata = '0;
        m_d_rdata = '0;
      end
      cyc++;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic wait_acc(input int who);
    bit ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge CLK);
      #1;
      ok = (who == 1) ? d_acc_seen : i_acc_seen;
    end
    check_eq((who == 1) ? "d_accept" : "i_accept", ok, 1);
  endtask

  task automatic send_i(input logic [ADDR_W-1:0] a);
    @(posedge CLK); #1;
    i_req_valid = 1'b1;
    i_addr      = a;
    wait_acc(0);
    @(posedge CLK); #1;
    i_req_valid = 1'b0;
  endtask

  task automatic send_d(input logic [ADDR_W-1:0] a, input logic [MASK_W-1:0] m,
                        input logic [DATA_W-1:0] wd);
    @(posedge CLK); #1;
    d_req_valid = 1'b1;
    d_addr      = a;
    d_wmask     = m;
    d_wdata     = wd;
    wait_acc(1);
    @(posedge CLK); #1;
    d_req_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    int               men0, irsp0;
    logic [DATA_W-1:0] saved;

    for (int w = 0; w < WORDS; w++) begin
      slave_mem[w] = $urandom;
      ref_mem[w]   = slave_mem[w];
    end
    slave_mem[4] = 32'h0010_0073;
    ref_mem[4]   = 32'h0010_0073;

    // Reset: a valid fetch held during reset must not be handshaken.
    i_req_valid = 1'b1;
    i_addr      = 32'h10;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_eq("rst_i_ready", i_req_ready, 0);
    check_eq("rst_mem_en", mem_en, 0);
    check_eq("rst_i_rdata", i_rdata, 0);
    @(posedge CLK); #1;
    i_req_valid = 1'b0;
    resetn      = 1'b1;

    // Fetch of word 4
    send_i(32'h10);
    repeat (4) @(negedge CLK);
    check_eq("fetch_mem_addr", last_men_addr, 32'h10);
    check_eq("fetch_rdata", i_rdata, 32'h0010_0073);

    // Store then read back
    send_d(32'h0C, 4'hF, 32'hDEAD_BEEF);
    repeat (4) @(negedge CLK);
    check_eq("store_wmask", last_men_wmask, 4'hF);
    check_eq("store_rdata_zero", d_rdata, 0);
    send_d(32'h0C, 4'h0, 32'h0);
    repeat (4) @(negedge CLK);
    check_eq("readback", d_rdata, 32'hDEAD_BEEF);

    // Misaligned read
    send_d(32'h0B, 4'h0, 32'h0);
    repeat (4) @(negedge CLK);
    check_eq("misaligned_addr", last_men_addr, 32'h08);

    // Data request withdrawn while a fetch is in progress
    saved = slave_mem[12];
    men0  = men_cnt;
    send_i(32'h20);
    d_req_valid = 1'b1;
    d_addr      = 32'h30;
    d_wmask     = 4'hF;
    d_wdata     = 32'h1234_5678;
    @(posedge CLK); #1;
    d_req_valid = 1'b0;
    repeat (8) @(negedge CLK);
    check_eq("dropped_d_men_cnt", men_cnt - men0, 1);
    check_eq("dropped_d_mem", slave_mem[12], saved);

    // Reset while a fetch is in WAIT
    irsp0 = irsp_cnt;
    send_i(32'h14);        // returns in the ACCESS cycle
    @(posedge CLK); #1;    // WAIT cycle
    resetn = 1'b0;
    @(posedge CLK); #1;
    resetn = 1'b1;
    repeat (4) @(negedge CLK);
    check_eq("rst_wait_no_rsp", irsp_cnt - irsp0, 0);
    send_i(32'h10);
    repeat (4) @(negedge CLK);
    check_eq("after_rst_fetch", i_rdata, 32'h0010_0073);

    // Both requesters valid continuously right after reset
    @(posedge CLK); #1;
    resetn = 1'b0;
    @(posedge CLK); #1;
    resetn      = 1'b1;
    i_req_valid = 1'b1;
    i_addr      = 32'h20;
    d_req_valid = 1'b1;
    d_addr      = 32'h24;
    d_wmask     = 4'h0;
    log_en      = 1'b1;
    repeat (26) @(posedge CLK);
    #1;
    log_en      = 1'b0;
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    check_eq("alt_grant_count", grant_id_q.size(), 7);
    for (int k = 0; k < grant_id_q.size(); k++) begin
      check_eq("alt_grant_id", grant_id_q[k], k % 2);
      if (k > 0) check_eq("alt_grant_spacing", grant_cyc_q[k] - grant_cyc_q[k-1], 4);
    end

    // Randomized traffic, occasional withdrawals and resets
    for (int k = 0; k < 3000; k++) begin
      @(posedge CLK); #1;
      resetn = ($urandom_range(0, 199) != 0);
      if (i_req_valid && i_acc_seen) begin
        i_req_valid = 1'b0;
      end else if (i_req_valid && $urandom_range(0, 15) == 0) begin
        i_req_valid = 1'b0;
      end else if (!i_req_valid && $urandom_range(0, 2) == 0) begin
        i_req_valid = 1'b1;
        i_addr      = $urandom_range(0, WORDS*4 - 1);
      end
      if (d_req_valid && d_acc_seen) begin
        d_req_valid = 1'b0;
      end else if (d_req_valid && $urandom_range(0, 15) == 0) begin
        d_req_valid = 1'b0;
      end else if (!d_req_valid && $urandom_range(0, 2) == 0) begin
        d_req_valid = 1'b1;
        d_addr      = $urandom_range(0, WORDS*4 - 1);
        d_wmask     = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        d_wdata     = $urandom;
      end
    end

    @(posedge CLK); #1;
    resetn      = 1'b1;
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    repeat (8) @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_mem_port_arbiter
`default_nettype wire
